daa_scalar_ctrl: RTL and testbench

- Parametrised double-and-add-always scalar-multiplication controller; computes Q = k·P on the ECC datapath.
- Scans the scalar MSB-first and issues one point-double then one point-add per bit after the leading 1, regardless of bit value. This gives a constant operation count for a given scalar length.
- Point arithmetic is delegated to an external point unit over a req/done handshake.
- Sits between the top-level ECC FSM and the point add/double unit.

---
 rtl/daa_scalar_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_daa_scalar_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/daa_scalar_ctrl.sv
// Double-and-add-always scalar multiplication controller: scans k MSB-first and
// drives an external point unit through a req/done handshake to form Q = k*P.
module daa_scalar_ctrl #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned IDX_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             daa_valid,
  input  logic [1:0]       daa_mode,
  input  logic [WIDTH-1:0] i_daa_pointx,
  input  logic [WIDTH-1:0] i_daa_pointy,
  input  logic [WIDTH-1:0] i_daa_prime,
  input  logic [WIDTH-1:0] i_daa_mul,
  output logic             o_daa_busy,
  output logic             o_daa_finished,
  output logic             o_daa_inf,
  output logic [WIDTH-1:0] o_daa_outputx,
  output logic [WIDTH-1:0] o_daa_outputy,
  output logic             o_pu_req,
  output logic             o_pu_op,
  output logic [WIDTH-1:0] o_pu_x1,
  output logic [WIDTH-1:0] o_pu_y1,
  output logic [WIDTH-1:0] o_pu_x2,
  output logic [WIDTH-1:0] o_pu_y2,
  output logic [WIDTH-1:0] o_pu_prime,
  input  logic             i_pu_done,
  input  logic [WIDTH-1:0] i_pu_x,
  input  logic [WIDTH-1:0] i_pu_y
);

  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_DBL, S_ADD, S_SEL, S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [WIDTH-1:0] r_k, w_k_nxt;
  logic [WIDTH-1:0] r_px, w_px_nxt, r_py, w_py_nxt;
  logic [WIDTH-1:0] r_prime, w_prime_nxt;
  logic             r_neg, w_neg_nxt;
  logic [WIDTH-1:0] r_r0x, w_r0x_nxt, r_r0y, w_r0y_nxt;
  logic [WIDTH-1:0] r_r1x, w_r1x_nxt, r_r1y, w_r1y_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_fin, w_fin_nxt;
  logic             r_inf, w_inf_nxt;
  logic [WIDTH-1:0] r_outx, w_outx_nxt, r_outy, w_outy_nxt;
  logic             r_req, w_req_nxt;
  logic             r_op, w_op_nxt;
  logic             w_kbit;
  logic             w_idx_zero;
  logic             w_pu_ack;

  // Next-state, datapath and output logic
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_k_nxt     = r_k;
    w_px_nxt    = r_px;
    w_py_nxt    = r_py;
    w_prime_nxt = r_prime;
    w_neg_nxt   = r_neg;
    w_r0x_nxt   = r_r0x;
    w_r0y_nxt   = r_r0y;
    w_r1x_nxt   = r_r1x;
    w_r1y_nxt   = r_r1y;
    w_busy_nxt  = r_busy;
    w_fin_nxt   = 1'b0;
    w_inf_nxt   = r_inf;
    w_outx_nxt  = r_outx;
    w_outy_nxt  = r_outy;
    w_req_nxt   = r_req;
    w_op_nxt    = r_op;
    w_kbit      = 1'(r_k >> r_idx);
    w_idx_zero  = (r_idx == '0);
    w_pu_ack    = r_req && i_pu_done;

    case (r_state)
      S_IDLE: begin
        if (daa_valid) begin
          w_px_nxt    = i_daa_pointx;
          w_py_nxt    = i_daa_pointy;
          w_prime_nxt = i_daa_prime;
          w_k_nxt     = i_daa_mul;
          w_neg_nxt   = (daa_mode == 2'd1);
          w_idx_nxt   = IDX_TOP;
          w_busy_nxt  = 1'b1;
          w_inf_nxt   = 1'b0;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_kbit) begin
          w_r0x_nxt = r_px;
          w_r0y_nxt = r_py;
          if (w_idx_zero) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx - IDX_W'(1);
            w_req_nxt   = 1'b1;
            w_op_nxt    = 1'b0;
            w_state_nxt = S_DBL;
          end
        end else if (w_idx_zero) begin
          w_inf_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt = r_idx - IDX_W'(1);
        end
      end
      S_DBL: begin
        if (w_pu_ack) begin
          w_r0x_nxt   = i_pu_x;
          w_r0y_nxt   = i_pu_y;
          w_req_nxt   = 1'b0;
          w_state_nxt = S_ADD;
        end
      end
      // First ADD cycle keeps req low so requests are always separated
      S_ADD: begin
        if (!r_req) begin
          w_req_nxt = 1'b1;
          w_op_nxt  = 1'b1;
        end else if (i_pu_done) begin
          w_r1x_nxt   = i_pu_x;
          w_r1y_nxt   = i_pu_y;
          w_req_nxt   = 1'b0;
          w_state_nxt = S_SEL;
        end
      end
      S_SEL: begin
        if (w_kbit) begin
          w_r0x_nxt = r_r1x;
          w_r0y_nxt = r_r1y;
        end
        if (w_idx_zero) begin
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx - IDX_W'(1);
          w_req_nxt   = 1'b1;
          w_op_nxt    = 1'b0;
          w_state_nxt = S_DBL;
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Result registers are loaded on DONE entry so finished and data align
    if (w_state_nxt == S_DONE) begin
      w_fin_nxt = 1'b1;
      if (w_inf_nxt) begin
        w_outx_nxt = '0;
        w_outy_nxt = '0;
      end else begin
        w_outx_nxt = w_r0x_nxt;
        if (r_neg && (w_r0y_nxt != '0)) w_outy_nxt = r_prime - w_r0y_nxt;
        else                            w_outy_nxt = w_r0y_nxt;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_k     <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_prime <= '0;
      r_neg   <= 1'b0;
      r_r0x   <= '0;
      r_r0y   <= '0;
      r_r1x   <= '0;
      r_r1y   <= '0;
      r_busy  <= 1'b0;
      r_fin   <= 1'b0;
      r_inf   <= 1'b0;
      r_outx  <= '0;
      r_outy  <= '0;
      r_req   <= 1'b0;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_k     <= w_k_nxt;
      r_px    <= w_px_nxt;
      r_py    <= w_py_nxt;
      r_prime <= w_prime_nxt;
      r_neg   <= w_neg_nxt;
      r_r0x   <= w_r0x_nxt;
      r_r0y   <= w_r0y_nxt;
      r_r1x   <= w_r1x_nxt;
      r_r1y   <= w_r1y_nxt;
      r_busy  <= w_busy_nxt;
      r_fin   <= w_fin_nxt;
      r_inf   <= w_inf_nxt;
      r_outx  <= w_outx_nxt;
      r_outy  <= w_outy_nxt;
      r_req   <= w_req_nxt;
      r_op    <= w_op_nxt;
    end
  end

  assign o_daa_busy     = r_busy;
  assign o_daa_finished = r_fin;
  assign o_daa_inf      = r_inf;
  assign o_daa_outputx  = r_outx;
  assign o_daa_outputy  = r_outy;
  assign o_pu_req       = r_req;
  assign o_pu_op        = r_op;
  assign o_pu_x1        = r_r0x;
  assign o_pu_y1        = r_r0y;
  assign o_pu_x2        = r_px;
  assign o_pu_y2        = r_py;
  assign o_pu_prime     = r_prime;

endmodule

// File: tb/tb_daa_scalar_ctrl.sv
// Scoreboard bench for daa_scalar_ctrl at WIDTH=8 with a linear point-unit model,
// so every result is k*P per component (mod 256).
module tb_daa_scalar_ctrl;
  localparam int unsigned W  = 8;
  localparam int unsigned IW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         daa_valid;
  logic [1:0]   daa_mode;
  logic [W-1:0] i_daa_pointx, i_daa_pointy, i_daa_prime, i_daa_mul;
  logic         o_daa_busy, o_daa_finished, o_daa_inf;
  logic [W-1:0] o_daa_outputx, o_daa_outputy;
  logic         o_pu_req, o_pu_op;
  logic [W-1:0] o_pu_x1, o_pu_y1, o_pu_x2, o_pu_y2, o_pu_prime;
  logic         i_pu_done;
  logic [W-1:0] i_pu_x, i_pu_y;

  daa_scalar_ctrl #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .daa_valid(daa_valid), .daa_mode(daa_mode),
    .i_daa_pointx(i_daa_pointx), .i_daa_pointy(i_daa_pointy),
    .i_daa_prime(i_daa_prime), .i_daa_mul(i_daa_mul),
    .o_daa_busy(o_daa_busy), .o_daa_finished(o_daa_finished), .o_daa_inf(o_daa_inf),
    .o_daa_outputx(o_daa_outputx), .o_daa_outputy(o_daa_outputy),
    .o_pu_req(o_pu_req), .o_pu_op(o_pu_op),
    .o_pu_x1(o_pu_x1), .o_pu_y1(o_pu_y1), .o_pu_x2(o_pu_x2), .o_pu_y2(o_pu_y2),
    .o_pu_prime(o_pu_prime), .i_pu_done(i_pu_done), .i_pu_x(i_pu_x), .i_pu_y(i_pu_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    bit           inf;
    int           nops;
    int           busy;  // expected busy-cycle count, -1 when not checked
  } exp_t;

  exp_t exp_q[$];
  bit   op_log[$];
  int   total = 0;
  int   bad   = 0;
  int   fin_cnt = 0;
  int   pu_delay = 0;
  bit   late_req = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on k*P
  function automatic exp_t model(input logic [W-1:0] k, input logic [W-1:0] px,
                                 input logic [W-1:0] py, input logic [W-1:0] prime,
                                 input logic [1:0] mode, input int busy);
    exp_t e;
    int   t;
    e.inf  = (k == 0);
    e.x    = W'(int'(k) * int'(px));
    e.y    = W'(int'(k) * int'(py));
    e.busy = busy;
    t = 0;
    for (int i = 0; i < int'(W); i++) if (k[i]) t = i;
    e.nops = e.inf ? 0 : 2 * t;
    if (e.inf) begin
      e.x = '0;
      e.y = '0;
    end else if (mode == 2'd1 && e.y != 0) begin
      e.y = W'(int'(prime) - int'(e.y));
    end
    return e;
  endfunction

  // Point-unit model: doubles or sums component-wise after pu_delay cycles
  initial begin
    int           cnt;
    bit           served, seen;
    logic [W-1:0] cx1, cy1, cx2, cy2;
    i_pu_done = 0; i_pu_x = '0; i_pu_y = '0;
    cnt = 0; served = 0; seen = 0;
    cx1 = '0; cy1 = '0; cx2 = '0; cy2 = '0;
    forever begin
      @(posedge clk); #1;
      i_pu_done = 0;
      if (late_req) begin
        i_pu_done = 1;
        i_pu_x = 8'hAA;
        i_pu_y = 8'h55;
      end else if (o_pu_req && !served) begin
        if (!seen) begin
          seen = 1;
          cx1 = o_pu_x1; cy1 = o_pu_y1; cx2 = o_pu_x2; cy2 = o_pu_y2;
          op_log.push_back(o_pu_op);
        end
        if (cnt >= pu_delay) begin
          if (pu_delay > 0) begin
            check("operand_stable",
                  int'({o_pu_x1, o_pu_y1} == {cx1, cy1}) +
                  int'(!o_pu_op || ({o_pu_x2, o_pu_y2} == {cx2, cy2})), 2);
          end
          if (o_pu_op) begin
            i_pu_x = o_pu_x1 + o_pu_x2;
            i_pu_y = o_pu_y1 + o_pu_y2;
          end else begin
            i_pu_x = W'(2 * int'(o_pu_x1));
            i_pu_y = W'(2 * int'(o_pu_y1));
          end
          i_pu_done = 1;
          served = 1;
        end else begin
          cnt++;
        end
      end
      if (!o_pu_req) begin
        served = 0; seen = 0; cnt = 0;
      end
      if (!o_daa_busy) op_log.delete();
    end
  end

  // Monitor: pops the scoreboard on every finished pulse
  initial begin
    int   busy_cnt;
    int   order_err;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (o_daa_busy) busy_cnt++;
      else busy_cnt = 0;
      if (o_daa_finished) begin
        if (exp_q.size() == 0) begin
          check("unexpected_finished", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_x", int'(o_daa_outputx), int'(e.x));
          check("out_y", int'(o_daa_outputy), int'(e.y));
          check("out_inf", int'(o_daa_inf), int'(e.inf));
          check("op_count", op_log.size(), e.nops);
          order_err = 0;
          foreach (op_log[i]) if (op_log[i] != bit'(i % 2)) order_err++;
          check("op_order_errors", order_err, 0);
          if (e.busy >= 0) check("busy_cycles", busy_cnt, e.busy);
        end
        fin_cnt++;
      end
    end
  end

  task automatic start(input logic [W-1:0] k, input logic [W-1:0] px,
                       input logic [W-1:0] py, input logic [W-1:0] prime,
                       input logic [1:0] mode, input int busy, input bit push);
    if (push) exp_q.push_back(model(k, px, py, prime, mode, busy));
    @(negedge clk);
    i_daa_mul = k; i_daa_pointx = px; i_daa_pointy = py;
    i_daa_prime = prime; daa_mode = mode; daa_valid = 1;
    @(negedge clk);
    daa_valid = 0;
  endtask

  task automatic wait_finish();
    int f0;
    bit got;
    f0 = fin_cnt;
    got = 0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      if (fin_cnt != f0) got = 1;
    end
    if (!got) check("finish_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit got;
    rst = 0; daa_valid = 0; daa_mode = 0;
    i_daa_pointx = 0; i_daa_pointy = 0; i_daa_prime = 0; i_daa_mul = 0;
    #12;
    check("rst_busy", int'(o_daa_busy), 0);
    check("rst_finished", int'(o_daa_finished), 0);
    check("rst_req", int'(o_pu_req), 0);
    check("rst_out", int'({o_daa_outputx, o_daa_outputy, o_daa_inf}), 0);
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);

    // k = 0 and k = 1: no point operations, 9 busy cycles
    pu_delay = 0;
    start(8'h00, 8'd3, 8'd5, 8'd251, 2'd0, 9, 1); wait_finish();
    start(8'h01, 8'd3, 8'd5, 8'd251, 2'd0, 9, 1); wait_finish();

    pu_delay = 1;
    start(8'h0B, 8'd1, 8'd2, 8'd251, 2'd0, -1, 1); wait_finish();

    pu_delay = 0;
    start(8'h05, 8'd2, 8'd3, 8'd251, 2'd1, -1, 1); wait_finish();
    start(8'h05, 8'd2, 8'd3, 8'd251, 2'd3, -1, 1); wait_finish();

    // Long waits, an ignored mid-run start, and held outputs afterwards
    pu_delay = 7;
    start(8'hFF, 8'd1, 8'd1, 8'd251, 2'd0, -1, 1);
    repeat (30) @(negedge clk);
    i_daa_mul = 8'h00; daa_valid = 1;
    @(negedge clk); daa_valid = 0;
    wait_finish();
    i_daa_pointx = 8'd9; i_daa_mul = 8'd7;
    repeat (5) @(negedge clk);
    check("held_x", int'(o_daa_outputx), 255);
    check("held_y", int'(o_daa_outputy), 255);

    // Randomised runs
    for (int n = 0; n < 20; n++) begin
      pu_delay = $urandom_range(0, 3);
      start(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
            W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
            2'($urandom_range(0, 3)), -1, 1);
      wait_finish();
    end

    // Reset during an ADD wait, then a stray late done
    pu_delay = 20;
    start(8'h80, 8'd4, 8'd4, 8'd251, 2'd0, -1, 0);
    got = 0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      if (o_pu_req && o_pu_op) got = 1;
    end
    check("reached_add_wait", int'(got), 1);
    #2 rst = 0;
    #1;
    check("abort_req", int'(o_pu_req), 0);
    check("abort_busy", int'(o_daa_busy), 0);
    check("abort_out", int'({o_daa_outputx, o_daa_outputy, o_daa_inf, o_daa_finished}), 0);
    @(negedge clk); rst = 1;
    @(negedge clk); late_req = 1;
    @(negedge clk); late_req = 0;
    repeat (20) @(negedge clk);
    check("post_abort_busy", int'(o_daa_busy), 0);
    check("post_abort_req", int'(o_pu_req), 0);

    pu_delay = 0;
    start(8'h03, 8'd4, 8'd4, 8'd251, 2'd0, -1, 1); wait_finish();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
